// File: rtl/vec4_processor.sv
// Shader vector-op responder: one 4-lane 8.8 fixed-point operation per start pulse,
// sequenced over a shared multiplier and a restoring square-root unit.
module vec4_processor #(
    parameter int DATA_WIDTH   = 16,
    parameter int VECTOR_WIDTH = 4,
    parameter int FRAC_BITS    = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               vp_start,
    input  logic [3:0]                         vp_operation,
    input  logic [DATA_WIDTH*VECTOR_WIDTH-1:0] vp_vec_a,
    input  logic [DATA_WIDTH*VECTOR_WIDTH-1:0] vp_vec_b,
    input  logic [DATA_WIDTH-1:0]              vp_scalar,
    output logic                               vp_busy,
    output logic                               vp_done,
    output logic [DATA_WIDTH*VECTOR_WIDTH-1:0] vp_result,
    output logic                               vp_result_valid
);

    // state     | meaning
    // S_IDLE    | waiting for vp_start
    // S_ALU     | lane-wise add/sub/min/max/reserved (compute, then finish)
    // S_MUL_SEQ | MUL/SCALE/DOT: one lane per cycle through the shared multiplier
    // S_SQRT    | LENGTH: 4 squaring cycles, 17 root iterations, finish
    // S_DONE    | one-cycle completion pulse; a new start is accepted here
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ALU     = 3'd1;
    localparam logic [2:0] S_MUL_SEQ = 3'd2;
    localparam logic [2:0] S_SQRT    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_MUL    = 4'd2;
    localparam logic [3:0] OP_DOT    = 4'd3;
    localparam logic [3:0] OP_SCALE  = 4'd4;
    localparam logic [3:0] OP_LENGTH = 4'd5;
    localparam logic [3:0] OP_MIN    = 4'd6;
    localparam logic [3:0] OP_MAX    = 4'd7;

    localparam int DW = DATA_WIDTH;
    localparam int VW = DATA_WIDTH * VECTOR_WIDTH;
    localparam int PW = 2 * DW + 2;

    localparam logic [4:0] CNT_LANES    = 5'd4;
    localparam logic [4:0] CNT_SQRT_END = 5'd21;

    localparam logic signed [PW-1:0] DOT_MAX = 34'sd32767;
    localparam logic signed [PW-1:0] DOT_MIN = -34'sd32768;

    logic [2:0]    state_q, state_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [3:0]    op_q, op_d;
    logic [VW-1:0] a_q, a_d;
    logic [VW-1:0] b_q, b_d;
    logic [DW-1:0] scl_q, scl_d;
    logic [PW-1:0] acc_q, acc_d;
    logic [DW+1:0] rem_q, rem_d;
    logic [DW:0]   root_q, root_d;
    logic [VW-1:0] tmp_q, tmp_d;
    logic [VW-1:0] result_q, result_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    function automatic logic [DW-1:0] lane_of(input logic [VW-1:0] v, input logic [1:0] i);
        return v[VW-1-DW*int'(i) -: DW];
    endfunction

    logic [1:0]           lane;
    logic [DW-1:0]        mul_x, mul_y;
    logic                 mul_signed;
    logic signed [DW:0]   mul_xe, mul_ye;
    logic signed [PW-1:0] prod;
    logic [DW-1:0]        prod_usat;

    assign lane = cnt_q[1:0];

    // Single shared multiplier; operands widened by one bit so signed and unsigned share it.
    always_comb begin
        mul_x      = lane_of(a_q, lane);
        mul_signed = (op_q == OP_DOT) || (op_q == OP_LENGTH);
        case (op_q)
            OP_SCALE:  mul_y = scl_q;
            OP_LENGTH: mul_y = lane_of(a_q, lane);
            default:   mul_y = lane_of(b_q, lane);
        endcase
        mul_xe = mul_signed ? $signed({mul_x[DW-1], mul_x}) : $signed({1'b0, mul_x});
        mul_ye = mul_signed ? $signed({mul_y[DW-1], mul_y}) : $signed({1'b0, mul_y});
        prod   = PW'(mul_xe) * PW'(mul_ye);
        if (|prod[2*DW-1:DW+FRAC_BITS]) begin
            prod_usat = '1;
        end else begin
            prod_usat = prod[DW+FRAC_BITS-1:FRAC_BITS];
        end
    end

    logic [VW-1:0] alu_res;

    always_comb begin
        alu_res = '0;
        for (int i = 0; i < VECTOR_WIDTH; i++) begin
            case (op_q)
                OP_ADD: alu_res[i*DW +: DW] = a_q[i*DW +: DW] + b_q[i*DW +: DW];
                OP_SUB: alu_res[i*DW +: DW] = a_q[i*DW +: DW] - b_q[i*DW +: DW];
                OP_MIN: alu_res[i*DW +: DW] =
                    ($signed(a_q[i*DW +: DW]) < $signed(b_q[i*DW +: DW])) ? a_q[i*DW +: DW] : b_q[i*DW +: DW];
                OP_MAX: alu_res[i*DW +: DW] =
                    ($signed(a_q[i*DW +: DW]) > $signed(b_q[i*DW +: DW])) ? a_q[i*DW +: DW] : b_q[i*DW +: DW];
                default: alu_res[i*DW +: DW] = '0;
            endcase
        end
    end

    logic signed [PW-1:0] dot_sh;
    logic [DW-1:0]        dot_sat;
    logic [DW+3:0]        rem_sh;
    logic [DW+3:0]        trial;
    logic                 sqrt_ge;
    logic [DW-1:0]        root_sat;

    always_comb begin
        dot_sh = $signed(acc_q) >>> FRAC_BITS;
        if (dot_sh > DOT_MAX) begin
            dot_sat = DOT_MAX[DW-1:0];
        end else if (dot_sh < DOT_MIN) begin
            dot_sat = DOT_MIN[DW-1:0];
        end else begin
            dot_sat = dot_sh[DW-1:0];
        end
        // Restoring root: bring down the next two radicand bits from the top of acc_q.
        rem_sh   = {rem_q, acc_q[PW-1:PW-2]};
        trial    = {1'b0, root_q, 2'b01};
        sqrt_ge  = (rem_sh >= trial);
        root_sat = root_q[DW] ? '1 : root_q[DW-1:0];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        scl_d    = scl_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        root_d   = root_q;
        tmp_d    = tmp_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (vp_start) begin
                    op_d   = vp_operation;
                    a_d    = vp_vec_a;
                    b_d    = vp_vec_b;
                    scl_d  = vp_scalar;
                    cnt_d  = '0;
                    acc_d  = '0;
                    rem_d  = '0;
                    root_d = '0;
                    busy_d = 1'b1;
                    case (vp_operation)
                        OP_MUL, OP_DOT, OP_SCALE: state_d = S_MUL_SEQ;
                        OP_LENGTH:                state_d = S_SQRT;
                        default:                  state_d = S_ALU;
                    endcase
                end
            end
            S_ALU: begin
                if (cnt_q == 5'd0) begin
                    tmp_d = alu_res;
                    cnt_d = 5'd1;
                end else begin
                    result_d = tmp_q;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_DONE;
                end
            end
            S_MUL_SEQ: begin
                if (cnt_q < CNT_LANES) begin
                    if (op_q == OP_DOT) begin
                        acc_d = acc_q + $unsigned(prod);
                    end else begin
                        tmp_d[VW-1-DW*int'(lane) -: DW] = prod_usat;
                    end
                    cnt_d = cnt_q + 5'd1;
                end else if ((op_q == OP_DOT) && (cnt_q == CNT_LANES)) begin
                    tmp_d = {dot_sat, {(VW-DW){1'b0}}};
                    cnt_d = cnt_q + 5'd1;
                end else begin
                    result_d = tmp_q;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_DONE;
                end
            end
            S_SQRT: begin
                if (cnt_q < CNT_LANES) begin
                    acc_d = acc_q + $unsigned(prod);
                    cnt_d = cnt_q + 5'd1;
                end else if (cnt_q < CNT_SQRT_END) begin
                    if (sqrt_ge) begin
                        rem_d  = (DW+2)'(rem_sh - trial);
                        root_d = {root_q[DW-1:0], 1'b1};
                    end else begin
                        rem_d  = rem_sh[DW+1:0];
                        root_d = {root_q[DW-1:0], 1'b0};
                    end
                    acc_d = {acc_q[PW-3:0], 2'b00};
                    cnt_d = cnt_q + 5'd1;
                end else begin
                    result_d = {root_sat, {(VW-DW){1'b0}}};
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            scl_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            root_q   <= '0;
            tmp_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            scl_q    <= scl_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            root_q   <= root_d;
            tmp_q    <= tmp_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign vp_busy         = busy_q;
    assign vp_done         = done_q;
    assign vp_result_valid = done_q;
    assign vp_result       = result_q;

endmodule

// File: tb/tb_vec4_processor.sv
// Bench for vec4_processor: arithmetic reference model checked every cycle,
// plus directed operations with hand-computed results and latencies.
module tb_vec4_processor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vp_start;
    logic [3:0]  vp_operation;
    logic [63:0] vp_vec_a;
    logic [63:0] vp_vec_b;
    logic [15:0] vp_scalar;
    logic        vp_busy;
    logic        vp_done;
    logic [63:0] vp_result;
    logic        vp_result_valid;

    int n_assert = 0;
    int n_fail   = 0;

    vec4_processor dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .vp_start        (vp_start),
        .vp_operation    (vp_operation),
        .vp_vec_a        (vp_vec_a),
        .vp_vec_b        (vp_vec_b),
        .vp_scalar       (vp_scalar),
        .vp_busy         (vp_busy),
        .vp_done         (vp_done),
        .vp_result       (vp_result),
        .vp_result_valid (vp_result_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] ln(input logic [63:0] v, input int i);
        return v[63-16*i -: 16];
    endfunction

    function automatic longint isqrt(input longint x);
        longint lo = 0;
        longint hi = 131072;
        longint mid;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= x) lo = mid;
            else hi = mid - 1;
        end
        return lo;
    endfunction

    function automatic logic [63:0] ref_op(input logic [3:0] op, input logic [63:0] a,
                                           input logic [63:0] b, input logic [15:0] s);
        logic [63:0] r = '0;
        longint acc = 0;
        longint p;
        logic signed [15:0] x, y;
        for (int i = 0; i < 4; i++) begin
            x = ln(a, i);
            y = ln(b, i);
            case (op)
                4'd0: r[63-16*i -: 16] = ln(a, i) + ln(b, i);
                4'd1: r[63-16*i -: 16] = ln(a, i) - ln(b, i);
                4'd2, 4'd4: begin
                    p = (longint'(ln(a, i)) * longint'((op == 4'd4) ? s : ln(b, i))) / 256;
                    r[63-16*i -: 16] = (p > 65535) ? 16'hFFFF : p[15:0];
                end
                4'd3: acc += longint'(x) * longint'(y);
                4'd5: acc += longint'(x) * longint'(x);
                4'd6: r[63-16*i -: 16] = (x < y) ? x : y;
                4'd7: r[63-16*i -: 16] = (x > y) ? x : y;
                default: ;
            endcase
        end
        if (op == 4'd3) begin
            p = acc >>> 8;
            if (p > 32767) p = 32767;
            if (p < -32768) p = -32768;
            r[63:48] = p[15:0];
        end
        if (op == 4'd5) begin
            p = isqrt(acc);
            r[63:48] = (p > 65535) ? 16'hFFFF : p[15:0];
        end
        return r;
    endfunction

    function automatic int ref_lat(input logic [3:0] op);
        case (op)
            4'd2, 4'd4: return 5;
            4'd3:       return 6;
            4'd5:       return 22;
            default:    return 2;
        endcase
    endfunction

    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    int          m_left = 0;
    logic [63:0] m_res  = '0;
    logic [63:0] m_pend = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_left <= 0;
            m_res  <= '0;
            m_pend <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_res  <= m_pend;
                end
                m_left <= m_left - 1;
            end else if (vp_start) begin
                m_busy <= 1'b1;
                m_left <= ref_lat(vp_operation);
                m_pend <= ref_op(vp_operation, vp_vec_a, vp_vec_b, vp_scalar);
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", 64'(vp_busy), 64'(m_busy));
        chk("done", 64'(vp_done), 64'(m_done));
        chk("valid", 64'(vp_result_valid), 64'(m_done));
        chk("result", vp_result, m_res);
    end

    // ---------------- directed stimulus ----------------
    task automatic run_op(input string name, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [15:0] s,
                          input logic [63:0] exp, input int exp_lat);
        int lat;
        vp_operation = op;
        vp_vec_a     = a;
        vp_vec_b     = b;
        vp_scalar    = s;
        vp_start     = 1'b1;
        @(negedge clk);
        vp_start = 1'b0;
        lat = 0;
        while (!vp_done && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk({name, " latency"}, 64'(lat), 64'(exp_lat));
        chk({name, " value"}, vp_result, exp);
    endtask

    initial begin
        int ndone;
        vp_start     = 1'b0;
        vp_operation = '0;
        vp_vec_a     = '0;
        vp_vec_b     = '0;
        vp_scalar    = '0;
        rst_n        = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("reset busy", 64'(vp_busy), 64'd0);
        chk("reset done", 64'(vp_done), 64'd0);
        chk("reset result", vp_result, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("add", 4'd0, 64'hFFFF_0001_8000_0000, 64'h0001_0001_8000_0000, 16'h0,
               64'h0000_0002_0000_0000, 2);
        run_op("reserved", 4'hC, 64'h1234_5678_9ABC_DEF0, 64'h1111_2222_3333_4444, 16'h55,
               64'h0, 2);
        run_op("sub", 4'd1, 64'h0005_0000_8000_1234, 64'h0006_0001_0001_0234, 16'h0,
               64'hFFFF_FFFF_7FFF_1000, 2);
        run_op("min", 4'd6, 64'h0100_FF00_7FFF_8000, 64'h0200_0100_8000_7FFF, 16'h0,
               64'h0100_FF00_8000_8000, 2);
        run_op("max", 4'd7, 64'h0100_FF00_7FFF_8000, 64'h0200_0100_8000_7FFF, 16'h0,
               64'h0200_0100_7FFF_7FFF, 2);
        run_op("mul", 4'd2, 64'h0200_FFFF_0180_0001, 64'h0300_FFFF_0200_00FF, 16'h0,
               64'h0600_FFFF_0300_0000, 5);
        run_op("scale half", 4'd4, 64'hFF00_0000_0000_FF00, 64'hDEAD_BEEF_DEAD_BEEF, 16'h0080,
               64'h7F80_0000_0000_7F80, 5);
        run_op("scale one", 4'd4, 64'hFF00_0000_0000_FF00, 64'h0, 16'h0100,
               64'hFF00_0000_0000_FF00, 5);
        run_op("dot", 4'd3, 64'h0100_0200_0000_0000, 64'h0300_0100_0000_0000, 16'h0,
               64'h0500_0000_0000_0000, 6);
        run_op("dot sat pos", 4'd3, 64'h7F00_7F00_7F00_7F00, 64'h7F00_7F00_7F00_7F00, 16'h0,
               64'h7FFF_0000_0000_0000, 6);
        run_op("dot neg", 4'd3, 64'hFF00_0000_0000_0000, 64'h0200_0000_0000_0000, 16'h0,
               64'hFE00_0000_0000_0000, 6);
        run_op("dot sat neg", 4'd3, 64'h8000_8000_8000_8000, 64'h7FFF_7FFF_7FFF_7FFF, 16'h0,
               64'h8000_0000_0000_0000, 6);
        run_op("length", 4'd5, 64'h0080_0080_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 16'h0,
               64'h00B5_0000_0000_0000, 22);
        run_op("length sat", 4'd5, 64'h8000_8000_8000_8000, 64'h0, 16'h0,
               64'hFFFF_0000_0000_0000, 22);
        run_op("length 345", 4'd5, 64'h0000_FD00_0000_FC00, 64'h0, 16'h0,
               64'h0500_0000_0000_0000, 22);

        // async reset ten cycles into a LENGTH, then a clean SCALE
        vp_operation = 4'd5;
        vp_vec_a     = 64'h0300_0400_0000_0000;
        vp_start     = 1'b1;
        @(negedge clk);
        vp_start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset busy", 64'(vp_busy), 64'd0);
        chk("midreset done", 64'(vp_done), 64'd0);
        chk("midreset valid", 64'(vp_result_valid), 64'd0);
        chk("midreset result", vp_result, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("scale after reset", 4'd4, 64'h0100_0200_0300_0400, 64'h0, 16'h0200,
               64'h0200_0400_0600_0800, 5);

        // start held high: exactly one extra accept, taken in the done cycle
        vp_operation = 4'd2;
        vp_vec_a     = 64'h0200_0200_0200_0200;
        vp_vec_b     = 64'h0300_0100_0080_0000;
        vp_start     = 1'b1;
        ndone        = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (vp_done) begin
                ndone++;
                if (ndone == 1) begin
                    chk("held first", vp_result, 64'h0600_0200_0100_0000);
                    vp_vec_a = 64'h0400_0400_0400_0400;
                    @(negedge clk);
                    vp_start = 1'b0;
                end else begin
                    chk("held second", vp_result, 64'h0C00_0400_0200_0000);
                end
            end
        end
        vp_start = 1'b0;
        chk("held done count", 64'(ndone), 64'd2);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
